// File: rtl/pusch_pkg.sv
// ---------------------------------------------------------------------------
// pusch_pkg
// Shared definitions for the per-beam power accumulator slice.
//   SW           : width of a reduced (shifted and clamped) I or Q sample
//   PW           : width of one instantaneous power value I^2 + Q^2
//   PIPE_DEPTH   : latency of the reduce/square/add datapath in cycles
//   DRAIN_CYCLES : cycles spent flushing that datapath after a packet ends
//   accState_e   : packet controller states
// ---------------------------------------------------------------------------
package pusch_pkg;

    localparam int SW           = 16;
    localparam int PW           = 32;
    localparam int PIPE_DEPTH   = 3;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        SCAN,
        DONE
    } accState_e;

endpackage

// File: rtl/cplx_pwr.sv
// ---------------------------------------------------------------------------
// cplx_pwr
// Instantaneous power of one complex sample, three registered stages:
//   stage 1 : arithmetic right shift by SHIFT, clamp to signed SW bits
//   stage 2 : square I and Q independently
//   stage 3 : add the two squares
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset, clears every stage
//   i_data_i : signed in-phase input, IW bits
//   i_data_q : signed quadrature input, IW bits
//   o_pwr    : unsigned I^2 + Q^2 of the reduced sample, PW bits,
//              valid PIPE_DEPTH cycles after the input was presented
// ---------------------------------------------------------------------------
module cplx_pwr
    import pusch_pkg::*;
#(
    parameter int IW    = 48,
    parameter int SHIFT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic signed [IW-1:0] i_data_i,
    input  logic signed [IW-1:0] i_data_q,
    output logic        [PW-1:0] o_pwr
);

    localparam logic signed [IW-1:0] RED_MAX = IW'((1 << (SW - 1)) - 1);
    localparam logic signed [IW-1:0] RED_MIN = ~RED_MAX;

    logic signed [SW-1:0]   redI_q, redQ_q, redI_d, redQ_d;
    logic signed [2*SW-1:0] prodI, prodQ;
    logic        [PW-1:0]   sqI_q, sqQ_q, sqI_d, sqQ_d;
    logic        [PW-1:0]   pwr_q, pwr_d;

    // Shift first and clamp afterwards, so that a large input pins to the
    // rails of the reduced range instead of wrapping to the opposite sign.
    function automatic logic signed [SW-1:0] reduce(input logic signed [IW-1:0] x);
        logic signed [IW-1:0] shifted;
        shifted = x >>> SHIFT;
        if (shifted > RED_MAX) begin
            reduce = RED_MAX[SW-1:0];
        end else if (shifted < RED_MIN) begin
            reduce = RED_MIN[SW-1:0];
        end else begin
            reduce = shifted[SW-1:0];
        end
    endfunction

    // Next values of all three stages. A square of a signed 16-bit value is
    // never negative and at most 2^30, so the product is reinterpreted as
    // unsigned and the sum of two squares never exceeds 2^31 within PW bits.
    always_comb begin
        redI_d = reduce(i_data_i);
        redQ_d = reduce(i_data_q);
        prodI  = redI_q * redI_q;
        prodQ  = redQ_q * redQ_q;
        sqI_d  = PW'(prodI);
        sqQ_d  = PW'(prodQ);
        pwr_d  = sqI_q + sqQ_q;
    end

    // The datapath runs every cycle; the top level tracks which outputs
    // belong to accepted samples, so no valid bit is carried here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            redI_q <= '0;
            redQ_q <= '0;
            sqI_q  <= '0;
            sqQ_q  <= '0;
            pwr_q  <= '0;
        end else begin
            redI_q <= redI_d;
            redQ_q <= redQ_d;
            sqI_q  <= sqI_d;
            sqQ_q  <= sqQ_d;
            pwr_q  <= pwr_d;
        end
    end

    assign o_pwr = pwr_q;

endmodule

// File: rtl/beam_pwr_acc.sv
// ---------------------------------------------------------------------------
// beam_pwr_acc
// Accumulates per-beam packet energy over a sop..eop packet, then scans the
// beams for the strongest one and publishes all results with a done pulse.
// Ports:
//   i_clk, i_reset      : clock and synchronous active-high reset
//   i_data_i, i_data_q  : per-beam summed I and Q, BEAM x IW signed
//   i_tvalid            : sample valid; sop/eop only count when it is high
//   i_sop, i_eop        : first and last sample of a packet
//   o_pwr               : per-beam packet energy, BEAM x AW, held between
//                         done pulses
//   o_max_idx,o_max_pwr : strongest beam (lowest index on ties) and energy
//   o_done              : one-cycle pulse when the results above update
//   o_sat               : some accumulator clipped since the last sop
//   o_overrun           : one-cycle pulse when a sop arrives too early and
//                         its packet is thrown away
// ---------------------------------------------------------------------------
module beam_pwr_acc
    import pusch_pkg::*;
#(
    parameter int BEAM  = 16,
    parameter int IW    = 48,
    parameter int SHIFT = 16,
    parameter int AW    = 48
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [BEAM-1:0][IW-1:0]        i_data_i,
    input  logic [BEAM-1:0][IW-1:0]        i_data_q,
    input  logic                           i_tvalid,
    input  logic                           i_sop,
    input  logic                           i_eop,
    output logic [BEAM-1:0][AW-1:0]        o_pwr,
    output logic [$clog2(BEAM)-1:0]        o_max_idx,
    output logic [AW-1:0]                  o_max_pwr,
    output logic                           o_done,
    output logic                           o_sat,
    output logic                           o_overrun
);

    localparam int              IDXW       = $clog2(BEAM);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(BEAM - 1);
    localparam logic [1:0]      DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    logic [PW-1:0]           beamPwr [BEAM];

    accState_e               state_q;
    logic [1:0]              drainCnt_q;
    logic [IDXW-1:0]         scanIdx_q, bestIdx_q, candIdx;
    logic [AW-1:0]           bestPwr_q, candPwr, scanPwr;
    logic                    dropPkt_q;

    logic                    sopTake, sampleTake, lateSop;
    logic [PIPE_DEPTH-1:0]   takePipe_q, loadPipe_q;

    logic [BEAM-1:0][AW-1:0] acc_q, acc_d;
    logic [AW:0]             accSum [BEAM];
    logic [BEAM-1:0]         satHit;
    logic                    sat_q, sat_d;

    // One power datapath per beam; all of them run in lockstep so a single
    // pair of take/load pipelines describes every beam's output.
    for (genvar b = 0; b < BEAM; b++) begin : g_beam
        cplx_pwr #(
            .IW    (IW),
            .SHIFT (SHIFT)
        ) u_cplx_pwr (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_data_i (i_data_i[b]),
            .i_data_q (i_data_q[b]),
            .o_pwr    (beamPwr[b])
        );
    end

    // Decide at the input whether a sample belongs to the packet being
    // accumulated. Only a sop seen in IDLE or ACC opens (or restarts) a
    // packet; a sop arriving while the previous packet is still being
    // drained, scanned or published is late and starts a dropped packet.
    always_comb begin
        sopTake    = i_tvalid && i_sop && !dropPkt_q &&
                     ((state_q == IDLE) || (state_q == ACC));
        sampleTake = sopTake || (i_tvalid && (state_q == ACC));
        lateSop    = i_tvalid && i_sop && !dropPkt_q &&
                     ((state_q == DRAIN) || (state_q == SCAN) || (state_q == DONE));
    end

    // The take/load decisions ride alongside the power datapath so they
    // meet the matching power value at the accumulator input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            takePipe_q <= '0;
            loadPipe_q <= '0;
        end else begin
            takePipe_q <= {takePipe_q[PIPE_DEPTH-2:0], sampleTake};
            loadPipe_q <= {loadPipe_q[PIPE_DEPTH-2:0], sopTake};
        end
    end

    // A sop sample replaces the accumulator rather than adding to it, which
    // covers both a fresh packet and a restart in the middle of one. Other
    // taken samples add with one extra carry bit to detect clipping, and a
    // clip pins the beam at all-ones and raises the sticky saturation flag.
    always_comb begin
        acc_d  = acc_q;
        satHit = '0;
        for (int b = 0; b < BEAM; b++) begin
            accSum[b] = {1'b0, acc_q[b]} + (AW + 1)'(beamPwr[b]);
            if (loadPipe_q[PIPE_DEPTH-1]) begin
                acc_d[b] = AW'(beamPwr[b]);
            end else if (takePipe_q[PIPE_DEPTH-1]) begin
                if (accSum[b][AW]) begin
                    acc_d[b]  = '1;
                    satHit[b] = 1'b1;
                end else begin
                    acc_d[b] = accSum[b][AW-1:0];
                end
            end
        end
        if (loadPipe_q[PIPE_DEPTH-1]) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q | (|satHit);
        end
    end

    // Accumulator and saturation flag registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign o_sat = sat_q;

    // Running maximum for the scan. Beam 0 always seeds the maximum, and a
    // later beam only takes over when strictly larger, so ties keep the
    // lowest index.
    always_comb begin
        scanPwr = acc_q[scanIdx_q];
        if ((scanIdx_q == '0) || (scanPwr > bestPwr_q)) begin
            candIdx = scanIdx_q;
            candPwr = scanPwr;
        end else begin
            candIdx = bestIdx_q;
            candPwr = bestPwr_q;
        end
    end

    // Packet controller. DRAIN waits out the datapath latency so the last
    // sample is in the accumulators before SCAN reads beam 0; SCAN visits
    // one beam per cycle and on the last beam publishes every result
    // together with the done pulse, so the outputs change only on done.
    // The drop flag swallows a late packet up to its eop; a late sop that
    // is also its own eop leaves nothing to swallow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            drainCnt_q <= '0;
            scanIdx_q  <= '0;
            bestIdx_q  <= '0;
            bestPwr_q  <= '0;
            dropPkt_q  <= 1'b0;
            o_pwr      <= '0;
            o_max_idx  <= '0;
            o_max_pwr  <= '0;
            o_done     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_overrun <= 1'b0;

            if (dropPkt_q && i_tvalid && i_eop) begin
                dropPkt_q <= 1'b0;
            end
            if (lateSop) begin
                o_overrun <= 1'b1;
                dropPkt_q <= !i_eop;
            end

            case (state_q)
                IDLE: begin
                    if (sopTake) begin
                        drainCnt_q <= '0;
                        state_q    <= i_eop ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (i_tvalid && i_eop) begin
                        drainCnt_q <= '0;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == DRAIN_LAST) begin
                        scanIdx_q <= '0;
                        state_q   <= SCAN;
                    end else begin
                        drainCnt_q <= drainCnt_q + 2'd1;
                    end
                end
                SCAN: begin
                    bestIdx_q <= candIdx;
                    bestPwr_q <= candPwr;
                    if (scanIdx_q == LAST_IDX) begin
                        o_pwr     <= acc_q;
                        o_max_idx <= candIdx;
                        o_max_pwr <= candPwr;
                        o_done    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        scanIdx_q <= scanIdx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beam_pwr_acc.sv
// ---------------------------------------------------------------------------
// tb_beam_pwr_acc
// Scoreboard bench for beam_pwr_acc. Packets are driven on the falling edge;
// each packet that should produce a result pushes its expected energies,
// strongest beam, saturation flag and done cycle into a queue, and a monitor
// pops and compares on every done pulse. The DUT uses AW=32 so that
// accumulator clipping is reachable within a few samples.
// ---------------------------------------------------------------------------
module tb_beam_pwr_acc;

    localparam int BEAM  = 16;
    localparam int IW    = 48;
    localparam int SHIFT = 16;
    localparam int AW    = 32;
    localparam longint ACC_MAX = (longint'(1) << AW) - 1;

    logic                          i_clk;
    logic                          i_reset;
    logic [BEAM-1:0][IW-1:0]       i_data_i;
    logic [BEAM-1:0][IW-1:0]       i_data_q;
    logic                          i_tvalid;
    logic                          i_sop;
    logic                          i_eop;
    logic [BEAM-1:0][AW-1:0]       o_pwr;
    logic [$clog2(BEAM)-1:0]       o_max_idx;
    logic [AW-1:0]                 o_max_pwr;
    logic                          o_done;
    logic                          o_sat;
    logic                          o_overrun;

    typedef struct {
        logic [BEAM-1:0][AW-1:0] pwr;
        int                      maxIdx;
        longint                  maxPwr;
        bit                      sat;
        int                      doneCycle;
    } expect_t;

    expect_t sbQ[$];
    int      checks       = 0;
    int      fails        = 0;
    int      cycleCnt     = 0;
    int      lastEopCycle = 0;
    int      overrunSeen  = 0;
    int      overrunExp   = 0;
    int      lastMaxIdx   = 0;
    longint  lastMaxPwr   = 0;

    beam_pwr_acc #(
        .BEAM  (BEAM),
        .IW    (IW),
        .SHIFT (SHIFT),
        .AW    (AW)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_data_i  (i_data_i),
        .i_data_q  (i_data_q),
        .i_tvalid  (i_tvalid),
        .i_sop     (i_sop),
        .i_eop     (i_eop),
        .o_pwr     (o_pwr),
        .o_max_idx (o_max_idx),
        .o_max_pwr (o_max_pwr),
        .o_done    (o_done),
        .o_sat     (o_sat),
        .o_overrun (o_overrun)
    );

    // Free-running clock and a count of rising edges used to time done.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference reduction and power straight from the arithmetic rules:
    // floor-divide by 2^SHIFT, clamp to signed 16 bits, sum the squares.
    function automatic longint refPower(input logic [IW-1:0] xi, input logic [IW-1:0] xq);
        longint vi, vq;
        vi = longint'($signed(xi)) >>> SHIFT;
        vq = longint'($signed(xq)) >>> SHIFT;
        if (vi > 32767) vi = 32767;
        if (vi < -32768) vi = -32768;
        if (vq > 32767) vq = 32767;
        if (vq < -32768) vq = -32768;
        return vi * vi + vq * vq;
    endfunction

    // Sample generators: 0 random reduced value with random fraction bits,
    // 1 full-width random (often clamps), 2 beam 5 at reduced 1, 3 every
    // beam at +32767, 4 beam 0 at -32768 on both rails, 5 tiny values so
    // that ties between beams are common.
    function automatic logic [IW-1:0] genSample(input int mode, input int beam);
        logic [15:0] r;
        logic [15:0] lo;
        logic [63:0] wide;
        lo = 16'($urandom());
        case (mode)
            0: begin
                r = 16'($urandom());
                return {{(IW-32){r[15]}}, r, lo};
            end
            1: begin
                wide = {$urandom(), $urandom()};
                return wide[IW-1:0];
            end
            2: return (beam == 5) ? IW'(48'h0000_0001_0000) : '0;
            3: return IW'(48'h7FFF_0000_0000);
            4: return (beam == 0) ? IW'(48'hFFFF_8000_0000) : '0;
            5: begin
                r = 16'($urandom_range(0, 4)) - 16'd2;
                return {{(IW-32){r[15]}}, r, lo};
            end
            default: return '0;
        endcase
    endfunction

    // Drives one packet of nSamp accepted samples with random invalid gaps
    // (carrying junk data and junk sop/eop), an optional restarting sop at
    // sample restartAt, and pushes the expected result when one is due.
    task automatic applyStimulus(input int nSamp, input int mode, input int gapPct,
                                 input int restartAt, input bit expectResult);
        longint  accM [BEAM];
        bit      satM;
        int      eopAt;
        longint  p;
        expect_t e;
        satM  = 1'b0;
        eopAt = 0;
        for (int b = 0; b < BEAM; b++) accM[b] = 0;
        for (int s = 0; s < nSamp; s++) begin
            if (s > 0) begin
                while ($urandom_range(0, 99) < gapPct) begin
                    i_tvalid = 1'b0;
                    i_sop    = 1'($urandom());
                    i_eop    = 1'($urandom());
                    for (int b = 0; b < BEAM; b++) begin
                        i_data_i[b] = genSample(1, b);
                        i_data_q[b] = genSample(1, b);
                    end
                    @(negedge i_clk);
                end
            end
            i_tvalid = 1'b1;
            i_sop    = (s == 0) || (s == restartAt);
            i_eop    = (s == nSamp - 1);
            for (int b = 0; b < BEAM; b++) begin
                i_data_i[b] = genSample(mode, b);
                i_data_q[b] = genSample(mode, b);
                p = refPower(i_data_i[b], i_data_q[b]);
                if (i_sop) begin
                    accM[b] = p;
                end else begin
                    accM[b] = accM[b] + p;
                    if (accM[b] > ACC_MAX) begin
                        accM[b] = ACC_MAX;
                        satM    = 1'b1;
                    end
                end
            end
            if (i_sop) satM = 1'b0;
            if (i_eop) eopAt = cycleCnt;
            @(negedge i_clk);
        end
        i_tvalid     = 1'b0;
        i_sop        = 1'b0;
        i_eop        = 1'b0;
        lastEopCycle = eopAt;
        if (expectResult) begin
            e.maxIdx = 0;
            e.maxPwr = accM[0];
            for (int b = 0; b < BEAM; b++) begin
                e.pwr[b] = accM[b][AW-1:0];
                if (accM[b] > e.maxPwr) begin
                    e.maxIdx = b;
                    e.maxPwr = accM[b];
                end
            end
            e.sat       = satM;
            e.doneCycle = eopAt + 4 + BEAM;
            sbQ.push_back(e);
        end
    endtask

    // Waits, within a cycle budget, for every queued result to be checked.
    task automatic waitResults(input int bound);
        int n = 0;
        while (sbQ.size() != 0 && n < bound) begin
            @(negedge i_clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL result_timeout pending=%0d expected=0", sbQ.size());
            sbQ.delete();
        end
        @(negedge i_clk);
    endtask

    task automatic waitUntilCycle(input int target);
        while (cycleCnt < target) @(negedge i_clk);
    endtask

    // Monitor: counts overrun pulses and checks every done pulse against
    // the oldest expected result, including the cycle it arrived in.
    always @(negedge i_clk) begin
        expect_t e;
        if (o_overrun) overrunSeen++;
        if (o_done) begin
            if (sbQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 cycle=%0d", cycleCnt);
            end else begin
                e = sbQ.pop_front();
                checkOutput("done_cycle", longint'(cycleCnt), longint'(e.doneCycle));
                for (int b = 0; b < BEAM; b++) begin
                    checkOutput($sformatf("pwr[%0d]", b), longint'(o_pwr[b]), longint'(e.pwr[b]));
                end
                checkOutput("max_idx", longint'(o_max_idx), longint'(e.maxIdx));
                checkOutput("max_pwr", longint'(o_max_pwr), e.maxPwr);
                checkOutput("sat", longint'(o_sat), longint'(e.sat));
                lastMaxIdx = e.maxIdx;
                lastMaxPwr = e.maxPwr;
            end
        end
    end

    // Checks that every output sits at its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pwr_any"}, longint'(|o_pwr), 0);
        checkOutput({tag, "_max_idx"}, longint'(o_max_idx), 0);
        checkOutput({tag, "_max_pwr"}, longint'(o_max_pwr), 0);
        checkOutput({tag, "_done"}, longint'(o_done), 0);
        checkOutput({tag, "_sat"}, longint'(o_sat), 0);
        checkOutput({tag, "_overrun"}, longint'(o_overrun), 0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed cases first, then randomized packets.
    initial begin
        int aEop;
        int n;
        int m;
        int rs;
        i_reset  = 1'b1;
        i_tvalid = 1'b0;
        i_sop    = 1'b0;
        i_eop    = 1'b0;
        i_data_i = '0;
        i_data_q = '0;
        repeat (3) @(negedge i_clk);
        checkResetState("reset");
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        $display("[TB] single beam, four samples");
        applyStimulus(4, 2, 0, -1, 1'b1);
        waitResults(200);

        $display("[TB] all beams at positive rail, one sample, tie");
        applyStimulus(1, 3, 0, -1, 1'b1);
        waitResults(200);

        $display("[TB] accumulator clipping on beam 0");
        applyStimulus(3, 4, 0, -1, 1'b1);
        waitResults(200);

        $display("[TB] packet with invalid gaps");
        applyStimulus(6, 0, 40, -1, 1'b1);
        waitResults(200);

        $display("[TB] sop in DONE dropped, sop right after DONE honoured");
        applyStimulus(3, 0, 0, -1, 1'b1);
        aEop = lastEopCycle;
        waitUntilCycle(aEop + 4 + BEAM);
        applyStimulus(1, 0, 0, -1, 1'b0);
        overrunExp++;
        applyStimulus(4, 5, 0, -1, 1'b1);
        waitResults(200);

        $display("[TB] short packet during SCAN dropped");
        applyStimulus(5, 0, 0, -1, 1'b1);
        aEop = lastEopCycle;
        waitUntilCycle(aEop + 8);
        applyStimulus(3, 1, 0, -1, 1'b0);
        overrunExp++;
        waitResults(200);

        $display("[TB] long packet from SCAN into IDLE dropped");
        applyStimulus(2, 0, 0, -1, 1'b1);
        aEop = lastEopCycle;
        waitUntilCycle(aEop + 10);
        applyStimulus(20, 1, 0, -1, 1'b0);
        overrunExp++;
        waitResults(200);
        applyStimulus(3, 0, 10, -1, 1'b1);
        waitResults(200);

        $display("[TB] restart mid-packet");
        applyStimulus(8, 1, 20, 4, 1'b1);
        waitResults(200);

        $display("[TB] reset two cycles after eop");
        applyStimulus(5, 1, 0, -1, 1'b0);
        waitUntilCycle(lastEopCycle + 2);
        i_reset = 1'b1;
        @(negedge i_clk);
        checkResetState("midreset");
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (30) @(negedge i_clk);
        applyStimulus(4, 0, 0, -1, 1'b1);
        waitResults(200);

        $display("[TB] randomized packets");
        for (int k = 0; k < 14; k++) begin
            n  = $urandom_range(1, 10);
            m  = $urandom_range(0, 2);
            rs = (n > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
            applyStimulus(n, (m == 0) ? 0 : ((m == 1) ? 1 : 5), $urandom_range(0, 40), rs, 1'b1);
            waitResults(200);
        end

        repeat (10) @(negedge i_clk);
        checkOutput("hold_max_idx", longint'(o_max_idx), longint'(lastMaxIdx));
        checkOutput("hold_max_pwr", longint'(o_max_pwr), lastMaxPwr);
        checkOutput("overrun_count", longint'(overrunSeen), longint'(overrunExp));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/beam_pwr_acc.md
BEAM_PWR_ACC -- requirements
Module: beam_pwr_acc

Interface
REQ-001 SHALL have parameter BEAM, default 16, number of beams.
REQ-002 SHALL have parameter IW, default 48, input I/Q width (signed).
REQ-003 SHALL have parameter SHIFT, default 16, arithmetic right shift applied before squaring.
REQ-004 SHALL have parameter AW, default 48, accumulator/power width (unsigned).
REQ-005 SHALL have port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports i_data_i and i_data_q, input, [BEAM-1:0][IW-1:0], per-beam summed I and Q.
REQ-008 SHALL have ports i_tvalid, i_sop and i_eop, input, 1 each; sample valid, first sample, last sample.
REQ-009 SHALL have port o_pwr, output, [BEAM-1:0][AW-1:0], per-beam packet energy.
REQ-010 SHALL have ports o_max_idx, output, $clog2(BEAM), and o_max_pwr, output, AW; strongest beam and its energy.
REQ-011 SHALL have port o_done, output, 1; one-cycle pulse, results valid.
REQ-012 SHALL have ports o_sat and o_overrun, output, 1 each; accumulator saturated, packet dropped.

Function
REQ-013 SHALL accept a sample only when i_tvalid=1; i_sop/i_eop with i_tvalid=0 are ignored.
REQ-014 SHALL reduce each I/Q sample to s = (x >>> SHIFT) saturated to signed 16 bits.
REQ-015 SHALL compute p = sI*sI + sQ*sQ as unsigned 32-bit (no overflow: max 2^31).
REQ-016 SHALL use a 3-stage pipeline (reduce, square, add) ahead of the accumulators; tvalid/sop/eop travel with the data.
REQ-017 SHALL use FSM states IDLE, ACC, DRAIN, SCAN, DONE.
REQ-018 IDLE->ACC on accepted sop; accumulators load that sample's p (not add to the old value).
REQ-019 ACC: each accepted sample adds p to acc[b], saturating at 2^AW-1; saturation sets o_sat (sticky until the next sop).
REQ-020 An accepted sop while in ACC SHALL restart the packet: accumulators reload and o_sat clears.
REQ-021 Accepted sop and eop together from IDLE SHALL form a one-sample packet.
REQ-022 An accepted eop at cycle T SHALL move the FSM to DRAIN for 3 cycles, then SCAN for BEAM cycles (one beam per cycle, index 0 first), then DONE for 1 cycle.
REQ-023 o_done SHALL be high in exactly cycle T+4+BEAM (T+20 at default BEAM); o_pwr, o_max_idx and o_max_pwr SHALL update in that same cycle and hold until the next o_done.
REQ-024 Ties in SCAN SHALL go to the lowest beam index (strictly-greater compare).
REQ-025 An accepted eop in IDLE, or without a prior sop, SHALL be ignored.
REQ-026 An accepted sop during DRAIN, SCAN or DONE SHALL be dropped, and the whole packet up to its eop SHALL be ignored; o_overrun pulses 1 cycle on that sop.
REQ-027 DONE->IDLE unconditionally; an accepted sop in the cycle after DONE SHALL be honoured.

Reset
REQ-028 While i_reset=1: FSM=IDLE, pipeline valids=0, accumulators=0, o_pwr=0, o_max_idx=0, o_max_pwr=0, o_done=0, o_sat=0, o_overrun=0.
REQ-029 Reset mid-packet or mid-SCAN SHALL abandon the packet with no o_done; the first accepted sop after release starts cleanly.

Structure
REQ-030 SHALL place the FSM state enum, the 16-bit reduced-sample width and the 32-bit power width in the shared package pusch_pkg.
REQ-031 SHALL use one sub-module, cplx_pwr (reduce + square + add, 3-cycle latency), instantiated BEAM times.

Verification
REQ-032 Beam 5 I=Q=0x1_0000 (reduced 1), others 0, packet of 4 samples -> o_pwr[5]=8, o_max_idx=5, o_done at T+20.
REQ-033 All beams I=0x7FFF_0000_0000 (reduced +32767), 1 sample -> each o_pwr=2*32767^2=2147352578, o_max_idx=0 (tie).
REQ-034 AW=32 override, beam 0 at p=2^31 for 3 samples -> o_pwr[0]=0xFFFFFFFF, o_sat=1.
REQ-035 sop accepted during SCAN -> o_overrun pulse, single o_done for the first packet, second packet ignored through its eop.
REQ-036 i_reset asserted 2 cycles after eop -> no o_done, all outputs 0; the next packet produces correct results.
REQ-037 i_tvalid=0 gaps inside a packet of 6 valid samples -> result equals the gap-free run.
